sha256_block_padder: RTL and testbench

Upstream feeder for the SHA-256 hash core: reads a NUM_OF_WORDS-word message from the shared testbench memory, applies standard SHA-256 padding (0x80000000 delimiter, zero fill, 64-bit bit-length), and presents the result one 512-bit block at a time over a valid/ready handshake. The hash core consumes each block and asserts ready when it can accept the next one. This removes the block-assembly and padding logic from the compression FSM, so the core only ever sees complete 16-word blocks.

---
 rtl/sha256_block_padder.sv | 222 ++++++++++++++++++++++
 tb/tb_sha256_block_padder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_padder.sv
// sha256_block_padder: reads an NUM_OF_WORDS-word message from memory, applies
// SHA-256 padding (0x80000000 delimiter, zero fill, 64-bit bit length) and
// hands out complete 512-bit blocks over a valid/ready handshake.
// Optional macro SHA256_PADDER_PREFETCH_EN adds a second 16-word buffer so the
// next block is fetched and padded while the current one waits in HOLD.
module sha256_block_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         done,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [511:0] block_data,
  output logic         block_last,
  output logic [7:0]   block_index
);

  localparam int          NB       = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam logic [63:0] MSG_BITS = 64'(NUM_OF_WORDS) * 64'd32;
  localparam logic [8:0]  LAST_BLK = 9'(NB - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PAD, HOLD} state_t;

  state_t      state;
  logic [15:0] base;
  logic [8:0]  blk;
  logic [8:0]  blk_nxt;
  logic [4:0]  fc;
  logic [4:0]  k_cur;
  logic [4:0]  k_nxt;
  logic        a_vld_p0;
  logic [3:0]  a_slot_p0;
  logic        d_vld_p1;
  logic [3:0]  d_slot_p1;
  logic        xfer;
  logic [31:0] buf_q   [16];
  logic [31:0] pad_blk [16];
`ifdef SHA256_PADDER_PREFETCH_EN
  logic [31:0] obuf_q  [16];
  logic        pend;
`endif

  // Number of message words that land in block b (0..16).
  function automatic logic [4:0] words_in(input logic [8:0] b);
    int rem;
    rem = NUM_OF_WORDS - 16 * int'(b);
    if (rem >= 16)     return 5'd16;
    else if (rem <= 0) return 5'd0;
    else               return 5'(rem);
  endfunction

  // Padding content of a slot that carries no message word.
  function automatic logic [31:0] pad_word(input logic [8:0] b, input logic [3:0] s);
    int gidx;
    gidx = 16 * int'(b) + int'(s);
    if (gidx == NUM_OF_WORDS)            return 32'h8000_0000;
    else if (b == LAST_BLK && s == 4'd14) return MSG_BITS[63:32];
    else if (b == LAST_BLK && s == 4'd15) return MSG_BITS[31:0];
    else                                  return 32'd0;
  endfunction

  assign mem_clk = clk;
  assign mem_we  = 1'b0;

  // Block bookkeeping and the padded view of the working buffer.
  always_comb begin
    blk_nxt = blk + 9'd1;
    k_cur   = words_in(blk);
    k_nxt   = words_in(blk_nxt);
    xfer    = block_valid && block_ready;
    for (int s = 0; s < 16; s++) begin
      pad_blk[s] = (5'(s) < k_cur) ? buf_q[s] : pad_word(blk, 4'(s));
    end
  end

  // Pack the presented buffer, word 0 in the top bits.
  always_comb begin
    block_data = '0;
    for (int s = 0; s < 16; s++) begin
`ifdef SHA256_PADDER_PREFETCH_EN
      block_data[511-32*s -: 32] = obuf_q[s];
`else
      block_data[511-32*s -: 32] = buf_q[s];
`endif
    end
  end

  // Control FSM, address issue, read capture and block handoff.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      done        <= 1'b1;
      mem_addr    <= 16'd0;
      block_valid <= 1'b0;
      block_last  <= 1'b0;
      block_index <= 8'd0;
      base        <= 16'd0;
      blk         <= 9'd0;
      fc          <= 5'd0;
      a_vld_p0    <= 1'b0;
      a_slot_p0   <= 4'd0;
      d_vld_p1    <= 1'b0;
      d_slot_p1   <= 4'd0;
      for (int s = 0; s < 16; s++) buf_q[s] <= 32'd0;
`ifdef SHA256_PADDER_PREFETCH_EN
      for (int s = 0; s < 16; s++) obuf_q[s] <= 32'd0;
      pend <= 1'b0;
`endif
    end else begin
      // stage p0 -> p1: address accepted by memory, data arrives next cycle
      d_vld_p1  <= a_vld_p0;
      d_slot_p1 <= a_slot_p0;
      // stage p1 -> buffer: capture the read word into its slot
      if (d_vld_p1) buf_q[d_slot_p1] <= mem_read_data;
`ifdef SHA256_PADDER_PREFETCH_EN
      if (xfer) block_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            base      <= message_addr;
            blk       <= 9'd0;
            fc        <= 5'd0;
            mem_addr  <= message_addr;
            a_vld_p0  <= 1'b1;
            a_slot_p0 <= 4'd0;
            done      <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          fc <= fc + 5'd1;
          if ((fc + 5'd1) < k_cur) begin
            mem_addr  <= mem_addr + 16'd1;
            a_vld_p0  <= 1'b1;
            a_slot_p0 <= a_slot_p0 + 4'd1;
          end else begin
            a_vld_p0  <= 1'b0;
          end
          if (fc == k_cur) state <= PAD;
        end
        PAD: begin
          for (int s = 0; s < 16; s++) buf_q[s] <= pad_blk[s];
`ifdef SHA256_PADDER_PREFETCH_EN
          if (!block_valid || xfer) begin
            for (int s = 0; s < 16; s++) obuf_q[s] <= pad_blk[s];
            block_valid <= 1'b1;
            block_last  <= (blk == LAST_BLK);
            block_index <= blk[7:0];
            if (blk == LAST_BLK) begin
              state <= HOLD;
            end else begin
              blk       <= blk_nxt;
              fc        <= 5'd0;
              mem_addr  <= base + 16'({blk_nxt, 4'b0000});
              a_vld_p0  <= (k_nxt != 5'd0);
              a_slot_p0 <= 4'd0;
              state     <= FETCH;
            end
          end else begin
            pend  <= 1'b1;
            state <= HOLD;
          end
`else
          block_valid <= 1'b1;
          block_last  <= (blk == LAST_BLK);
          block_index <= blk[7:0];
          state       <= HOLD;
`endif
        end
        HOLD: begin
`ifdef SHA256_PADDER_PREFETCH_EN
          if (xfer) begin
            if (block_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else if (pend) begin
              for (int s = 0; s < 16; s++) obuf_q[s] <= buf_q[s];
              block_valid <= 1'b1;
              block_last  <= (blk == LAST_BLK);
              block_index <= blk[7:0];
              pend        <= 1'b0;
              if (blk != LAST_BLK) begin
                blk       <= blk_nxt;
                fc        <= 5'd0;
                mem_addr  <= base + 16'({blk_nxt, 4'b0000});
                a_vld_p0  <= (k_nxt != 5'd0);
                a_slot_p0 <= 4'd0;
                state     <= FETCH;
              end
            end
          end
`else
          if (xfer) begin
            block_valid <= 1'b0;
            if (block_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              blk       <= blk_nxt;
              fc        <= 5'd0;
              mem_addr  <= base + 16'({blk_nxt, 4'b0000});
              a_vld_p0  <= (k_nxt != 5'd0);
              a_slot_p0 <= 4'd0;
              state     <= FETCH;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Bench for sha256_block_padder: four instances (20, 13, 14 and 16 words)
// share a random memory image; expected blocks come from a queue built with
// the textbook padding rule.
module tb_sha256_block_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   start, ready, done, we, bvalid, blast, mclk;
  logic [15:0]  min   [4];
  logic [15:0]  maddr [4];
  logic [511:0] bdata [4];
  logic [7:0]   bidx  [4];
  logic [31:0]  mem   [65536];
  logic [31:0]  exp_q [$];
  int n_chk, n_fail;

  generate
    for (genvar g = 0; g < 4; g++) begin : gen_dut
      localparam int NW = (g == 0) ? 20 : (g == 1) ? 13 : (g == 2) ? 14 : 16;
      logic [31:0] rd;
      always @(posedge clk) rd <= mem[maddr[g]];
      sha256_block_padder #(.NUM_OF_WORDS(NW)) u_dut (
        .clk(clk), .reset_n(rst_n), .start(start[g]), .message_addr(min[g]),
        .done(done[g]), .mem_clk(mclk[g]), .mem_we(we[g]), .mem_addr(maddr[g]),
        .mem_read_data(rd), .block_valid(bvalid[g]), .block_ready(ready[g]),
        .block_data(bdata[g]), .block_last(blast[g]), .block_index(bidx[g]));
    end
  endgenerate

  // Reference: message words, 0x80000000, zeros to 14 mod 16, 64-bit length.
  task automatic build_exp(input int n, input logic [15:0] base);
    logic [15:0] a;
    logic [63:0] len;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      exp_q.push_back(mem[a]);
    end
    exp_q.push_back(32'h8000_0000);
    while (exp_q.size() % 16 != 14) exp_q.push_back(32'd0);
    len = 64'(n) * 64'd32;
    exp_q.push_back(len[63:32]);
    exp_q.push_back(len[31:0]);
  endtask

  function automatic logic [511:0] exp_block(input int b);
    logic [511:0] r;
    r = '0;
    for (int s = 0; s < 16; s++) r[511-32*s -: 32] = exp_q[16*b+s];
    return r;
  endfunction

  function automatic logic [31:0] slot_of(input logic [511:0] d, input int s);
    return d[511-32*s -: 32];
  endfunction

  // Pulse start; returns at the falling edge of the first FETCH cycle.
  task automatic do_start(input int g, input logic [15:0] base);
    @(negedge clk);
    min[g]   = base;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_valid(input int g, input int bound, output int cnt);
    cnt = 0;
    while (bvalid[g] !== 1'b1 && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      n_chk++; if (done[g] !== 1'b1) begin n_fail++; $display("FAIL reset_done[%0d]: got %b want 1", g, done[g]); end
      n_chk++; if (we[g] !== 1'b0) begin n_fail++; $display("FAIL reset_we[%0d]: got %b want 0", g, we[g]); end
      n_chk++; if (maddr[g] !== 16'd0) begin n_fail++; $display("FAIL reset_addr[%0d]: got %h want 0", g, maddr[g]); end
      n_chk++; if (bvalid[g] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", g, bvalid[g]); end
      n_chk++; if (blast[g] !== 1'b0) begin n_fail++; $display("FAIL reset_last[%0d]: got %b want 0", g, blast[g]); end
      n_chk++; if (bidx[g] !== 8'd0) begin n_fail++; $display("FAIL reset_index[%0d]: got %0d want 0", g, bidx[g]); end
      n_chk++; if (bdata[g] !== 512'd0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h want 0", g, bdata[g]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_n20_basic();
    int lat;
    ready[0] = 1'b1;
    build_exp(20, 16'h0000);
    do_start(0, 16'h0000);
    n_chk++; if (done[0] !== 1'b0) begin n_fail++; $display("FAIL n20_done_low: got %b want 0", done[0]); end
    wait_valid(0, 40, lat);
    n_chk++; if (lat !== 18) begin n_fail++; $display("FAIL n20_lat0: got %0d want 18", lat); end
    n_chk++; if (bdata[0] !== exp_block(0)) begin n_fail++; $display("FAIL n20_data0: got %h want %h", bdata[0], exp_block(0)); end
    n_chk++; if (blast[0] !== 1'b0 || bidx[0] !== 8'd0) begin n_fail++; $display("FAIL n20_tag0: got last=%b idx=%0d want 0/0", blast[0], bidx[0]); end
    @(negedge clk);
    n_chk++; if (bvalid[0] !== 1'b0) begin n_fail++; $display("FAIL n20_valid_drop: got %b want 0", bvalid[0]); end
    wait_valid(0, 40, lat);
    n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL n20_lat1: got %0d want 6", lat); end
    n_chk++; if (bdata[0] !== exp_block(1)) begin n_fail++; $display("FAIL n20_data1: got %h want %h", bdata[0], exp_block(1)); end
    n_chk++; if (slot_of(bdata[0], 4) !== 32'h8000_0000 || slot_of(bdata[0], 15) !== 32'd640) begin n_fail++; $display("FAIL n20_pad1: got s4=%h s15=%0d want 80000000/640", slot_of(bdata[0], 4), slot_of(bdata[0], 15)); end
    n_chk++; if (blast[0] !== 1'b1 || bidx[0] !== 8'd1) begin n_fail++; $display("FAIL n20_tag1: got last=%b idx=%0d want 1/1", blast[0], bidx[0]); end
    @(negedge clk);
    n_chk++; if (done[0] !== 1'b1 || bvalid[0] !== 1'b0) begin n_fail++; $display("FAIL n20_done: got done=%b valid=%b want 1/0", done[0], bvalid[0]); end
    ready[0] = 1'b0;
  endtask

  task automatic test_n13_late_ready();
    int lat;
    logic [15:0] b;
    b = 16'($urandom);
    ready[1] = 1'b0;
    build_exp(13, b);
    do_start(1, b);
    wait_valid(1, 40, lat);
    n_chk++; if (lat !== 15) begin n_fail++; $display("FAIL n13_lat: got %0d want 15", lat); end
    repeat ($urandom_range(0, 5)) @(negedge clk);
    n_chk++; if (bdata[1] !== exp_block(0)) begin n_fail++; $display("FAIL n13_data: got %h want %h", bdata[1], exp_block(0)); end
    n_chk++; if (slot_of(bdata[1], 13) !== 32'h8000_0000 || slot_of(bdata[1], 14) !== 32'd0 || slot_of(bdata[1], 15) !== 32'd416) begin n_fail++; $display("FAIL n13_pad: got %h %h %h want 80000000 0 1a0", slot_of(bdata[1], 13), slot_of(bdata[1], 14), slot_of(bdata[1], 15)); end
    n_chk++; if (blast[1] !== 1'b1 || bvalid[1] !== 1'b1) begin n_fail++; $display("FAIL n13_last: got last=%b valid=%b want 1/1", blast[1], bvalid[1]); end
    ready[1] = 1'b1;
    @(negedge clk);
    n_chk++; if (done[1] !== 1'b1 || bvalid[1] !== 1'b0) begin n_fail++; $display("FAIL n13_done: got done=%b valid=%b want 1/0", done[1], bvalid[1]); end
    ready[1] = 1'b0;
  endtask

  task automatic test_n14_boundary();
    int lat;
    logic [15:0] b;
    b = 16'($urandom);
    ready[2] = 1'b1;
    build_exp(14, b);
    do_start(2, b);
    wait_valid(2, 40, lat);
    n_chk++; if (lat !== 16) begin n_fail++; $display("FAIL n14_lat0: got %0d want 16", lat); end
    n_chk++; if (bdata[2] !== exp_block(0)) begin n_fail++; $display("FAIL n14_data0: got %h want %h", bdata[2], exp_block(0)); end
    n_chk++; if (slot_of(bdata[2], 14) !== 32'h8000_0000 || slot_of(bdata[2], 15) !== 32'd0 || blast[2] !== 1'b0) begin n_fail++; $display("FAIL n14_pad0: got s14=%h s15=%h last=%b want 80000000/0/0", slot_of(bdata[2], 14), slot_of(bdata[2], 15), blast[2]); end
    @(negedge clk);
    wait_valid(2, 40, lat);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL n14_lat1: got %0d want 2", lat); end
    n_chk++; if (bdata[2] !== {480'd0, 32'd448} || bdata[2] !== exp_block(1)) begin n_fail++; $display("FAIL n14_data1: got %h want 1c0 in slot 15 only", bdata[2]); end
    n_chk++; if (blast[2] !== 1'b1 || bidx[2] !== 8'd1) begin n_fail++; $display("FAIL n14_tag1: got last=%b idx=%0d want 1/1", blast[2], bidx[2]); end
    @(negedge clk);
    n_chk++; if (done[2] !== 1'b1) begin n_fail++; $display("FAIL n14_done: got %b want 1", done[2]); end
    ready[2] = 1'b0;
  endtask

  task automatic test_hold_stall();
    int lat;
    logic [15:0] b;
    logic [511:0] held;
    b = 16'($urandom);
    ready[3] = 1'b0;
    build_exp(16, b);
    do_start(3, b);
    wait_valid(3, 40, lat);
    n_chk++; if (lat !== 18) begin n_fail++; $display("FAIL n16_lat0: got %0d want 18", lat); end
    n_chk++; if (bdata[3] !== exp_block(0)) begin n_fail++; $display("FAIL n16_data0: got %h want %h", bdata[3], exp_block(0)); end
    held = exp_block(0);
    for (int c = 0; c < 50; c++) begin
      if (c == 10) begin min[3] = ~b; start[3] = 1'b1; end
      if (c == 12) start[3] = 1'b0;
      @(negedge clk);
      n_chk++; if (bvalid[3] !== 1'b1 || bdata[3] !== held || bidx[3] !== 8'd0) begin n_fail++; $display("FAIL n16_hold_c%0d: got valid=%b idx=%0d data=%h", c, bvalid[3], bidx[3], bdata[3]); end
    end
    ready[3] = 1'b1;
    @(negedge clk);
    wait_valid(3, 40, lat);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL n16_lat1: got %0d want 2", lat); end
    n_chk++; if (slot_of(bdata[3], 0) !== 32'h8000_0000 || slot_of(bdata[3], 15) !== 32'd512 || bdata[3] !== exp_block(1)) begin n_fail++; $display("FAIL n16_data1: got %h want %h", bdata[3], exp_block(1)); end
    n_chk++; if (blast[3] !== 1'b1 || bidx[3] !== 8'd1) begin n_fail++; $display("FAIL n16_tag1: got last=%b idx=%0d want 1/1", blast[3], bidx[3]); end
    @(negedge clk);
    n_chk++; if (done[3] !== 1'b1) begin n_fail++; $display("FAIL n16_done: got %b want 1", done[3]); end
    ready[3] = 1'b0;
  endtask

  task automatic test_addr_wrap();
    int lat;
    logic [15:0] b;
    b = 16'hFFFE;
    ready[0] = 1'b1;
    build_exp(20, b);
    do_start(0, b);
    for (int j = 0; j < 16; j++) begin
      n_chk++; if (maddr[0] !== 16'(b + 16'(j))) begin n_fail++; $display("FAIL wrap_addr0_%0d: got %h want %h", j, maddr[0], 16'(b + 16'(j))); end
      @(negedge clk);
    end
    wait_valid(0, 40, lat);
    n_chk++; if (16 + lat !== 18) begin n_fail++; $display("FAIL wrap_lat0: got %0d want 18", 16 + lat); end
    n_chk++; if (bdata[0] !== exp_block(0)) begin n_fail++; $display("FAIL wrap_data0: got %h want %h", bdata[0], exp_block(0)); end
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      n_chk++; if (maddr[0] !== 16'(b + 16'(16 + j))) begin n_fail++; $display("FAIL wrap_addr1_%0d: got %h want %h", j, maddr[0], 16'(b + 16'(16 + j))); end
      @(negedge clk);
    end
    wait_valid(0, 40, lat);
    n_chk++; if (4 + lat !== 6) begin n_fail++; $display("FAIL wrap_lat1: got %0d want 6", 4 + lat); end
    n_chk++; if (bdata[0] !== exp_block(1)) begin n_fail++; $display("FAIL wrap_data1: got %h want %h", bdata[0], exp_block(1)); end
    @(negedge clk);
    ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] b;
    b = 16'($urandom);
    ready[0] = 1'b1;
    do_start(0, b);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if (done[0] !== 1'b1 || maddr[0] !== 16'd0 || we[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctl: got done=%b addr=%h we=%b want 1/0000/0", done[0], maddr[0], we[0]); end
    n_chk++; if (bvalid[0] !== 1'b0 || blast[0] !== 1'b0 || bidx[0] !== 8'd0) begin n_fail++; $display("FAIL rstmid_tag: got valid=%b last=%b idx=%0d want 0/0/0", bvalid[0], blast[0], bidx[0]); end
    n_chk++; if (bdata[0] !== 512'd0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", bdata[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    b = 16'($urandom);
    build_exp(20, b);
    do_start(0, b);
    wait_valid(0, 40, lat);
    n_chk++; if (lat !== 18) begin n_fail++; $display("FAIL rstmid_lat: got %0d want 18", lat); end
    n_chk++; if (bdata[0] !== exp_block(0) || bidx[0] !== 8'd0) begin n_fail++; $display("FAIL rstmid_data0: got %h want %h", bdata[0], exp_block(0)); end
    @(negedge clk);
    wait_valid(0, 40, lat);
    n_chk++; if (bdata[0] !== exp_block(1) || blast[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_data1: got %h want %h", bdata[0], exp_block(1)); end
    @(negedge clk);
    ready[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] b;
    ready[1] = 1'b1;
    for (int m = 0; m < 2; m++) begin
      b = 16'($urandom);
      build_exp(13, b);
      do_start(1, b);
      wait_valid(1, 40, lat);
      n_chk++; if (lat !== 15) begin n_fail++; $display("FAIL b2b_lat_%0d: got %0d want 15", m, lat); end
      n_chk++; if (bdata[1] !== exp_block(0)) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", m, bdata[1], exp_block(0)); end
    end
    ready[1] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    start = '0;
    ready = '0;
    for (int g = 0; g < 4; g++) min[g] = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    test_reset();
    test_n20_basic();
    test_n13_late_ready();
    test_n14_boundary();
    test_hold_stall();
    test_addr_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
